// File: rtl/fifo_pkg.sv
// Shared encodings for the FIFO drain path: the reader's buffer state is its occupancy.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer: head feeds dout, second catches a word that arrives while head stalls.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);

  occ_e                  state_p0, state_nxt;
  logic [DATA_WIDTH-1:0] head_p0, head_nxt;
  logic [DATA_WIDTH-1:0] second_p0, second_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= OCC_EMPTY;
      head_p0   <= '0;
      second_p0 <= '0;
    end else begin
      state_p0  <= state_nxt;
      head_p0   <= head_nxt;
      second_p0 <= second_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_p0;
    head_nxt   = head_p0;
    second_nxt = second_p0;
    case (state_p0)
      OCC_EMPTY: begin
        if (push) begin
          head_nxt  = din;
          state_nxt = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            second_nxt = din;
            state_nxt  = OCC_TWO;
          end
          2'b01: state_nxt = OCC_EMPTY;
          // Head retires and the incoming word replaces it in the same edge.
          2'b11: head_nxt = din;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop) begin
          head_nxt  = second_p0;
          state_nxt = OCC_ONE;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  assign dout = head_p0;
  assign occ  = state_p0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the gray-pointer FIFO into a valid/ready stream through a 2-entry buffer.
// Optional pop counter enabled by defining READER_POP_COUNT_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1
`ifdef READER_POP_COUNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr_act,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy
`ifdef READER_POP_COUNT_EN
  , output logic [CNT_WIDTH-1:0] pop_count
`endif
);

  logic [1:0] occ;
  logic       xfer;

  // Read only from registered occupancy so m_ready never reaches fifo_rd_en,
  // and never while the FIFO is writing the shared bus.
  assign fifo_rd_en = !rst && !fifo_empty && !fifo_wr_act && (occ != OCC_TWO);
  assign m_valid    = (occ != OCC_EMPTY);
  assign xfer       = m_valid && m_ready;
  assign occupancy  = occ;

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_rd_en),
    .pop  (xfer),
    .din  (fifo_data),
    .dout (m_data),
    .occ  (occ)
  );

`ifdef READER_POP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count <= '0;
    end else if (fifo_rd_en) begin
      pop_count <= pop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO source queue and expected-output queue as reference model.
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_wr_act;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    occupancy;
`ifdef READER_POP_COUNT_EN
  logic [3:0]    pop_count;
  int            model_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW)
`ifdef READER_POP_COUNT_EN
    , .CNT_WIDTH(4)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_wr_act (fifo_wr_act),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .occupancy   (occupancy)
`ifdef READER_POP_COUNT_EN
    , .pop_count (pop_count)
`endif
  );

  // One cycle, entered just after a negedge. Model: sb holds words popped but not yet consumed.
  task automatic step(input bit wr, input bit rdy,
                      output logic rd_s, output logic vld_s, output logic [DW-1:0] dat_s);
    bit            exp_rd, exp_vld, do_xfer;
    logic [DW-1:0] w;
    fifo_wr_act = wr;
    m_ready     = rdy;
    fifo_empty  = (src.size() == 0);
    fifo_data   = (src.size() != 0) ? src[0] : 8'h00;
    #1;
    rd_s  = fifo_rd_en;
    vld_s = m_valid;
    dat_s = m_data;
    exp_rd  = !rst && (src.size() != 0) && !wr && (sb.size() < 2);
    exp_vld = (sb.size() != 0);
    n_tests++;
    if (fifo_rd_en !== exp_rd) begin
      n_fail++;
      $display("FAIL rd_en: got %b expected %b (t=%0t)", fifo_rd_en, exp_rd, $time);
    end
    n_tests++;
    if ((fifo_rd_en & fifo_wr_act) !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_contention: rd_en&wr_act got %b expected 0 (t=%0t)", fifo_rd_en & fifo_wr_act, $time);
    end
    n_tests++;
    if (m_valid !== exp_vld) begin
      n_fail++;
      $display("FAIL m_valid: got %b expected %b (t=%0t)", m_valid, exp_vld, $time);
    end
    n_tests++;
    if (occupancy !== 2'(sb.size())) begin
      n_fail++;
      $display("FAIL occupancy: got %0d expected %0d (t=%0t)", occupancy, sb.size(), $time);
    end
    if (exp_vld) begin
      n_tests++;
      if (m_data !== sb[0]) begin
        n_fail++;
        $display("FAIL m_data: got %h expected %h (t=%0t)", m_data, sb[0], $time);
      end
    end
`ifdef READER_POP_COUNT_EN
    n_tests++;
    if (pop_count !== 4'(model_cnt)) begin
      n_fail++;
      $display("FAIL pop_count: got %0d expected %0d (t=%0t)", pop_count, model_cnt % 16, $time);
    end
`endif
    do_xfer = exp_vld && rdy && !rst;
    @(posedge clk);
    if (rst) begin
      sb.delete();
`ifdef READER_POP_COUNT_EN
      model_cnt = 0;
`endif
    end else begin
      if (do_xfer) begin
        void'(sb.pop_front());
        n_xfer++;
      end
      if (exp_rd) begin
        w = src.pop_front();
        sb.push_back(w);
`ifdef READER_POP_COUNT_EN
        model_cnt = (model_cnt + 1) % 16;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    logic r, v;
    logic [DW-1:0] d;
    int k;
    k = 0;
    while ((src.size() != 0 || sb.size() != 0) && k < budget) begin
      step(1'b0, 1'b1, r, v, d);
      k++;
    end
    n_tests++;
    if (src.size() != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: left src=%0d buf=%0d expected 0/0", src.size(), sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fifo_wr_act = 1'b0;
    m_ready = 1'b0;
    src.delete();
    src.push_back(8'h11);
    src.push_back(8'h22);
    fifo_empty = 1'b0;
    fifo_data = src[0];
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || occupancy !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state: got vld=%b data=%h occ=%0d expected 0/00/0", m_valid, m_data, occupancy);
      end
    end
    sb.delete();
    src.delete();
`ifdef READER_POP_COUNT_EN
    model_cnt = 0;
`endif
    rst = 1'b0;
  endtask

  task automatic test_burst;
    logic r, v;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
    for (int i = 0; i < 3; i++) src.push_back(exp_d[i]);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, r, v, d);
      n_tests++;
      if (r !== (i < 3)) begin
        n_fail++;
        $display("FAIL burst_rd_en[%0d]: got %b expected %b", i, r, (i < 3));
      end
      n_tests++;
      if (v !== (i >= 1 && i <= 3)) begin
        n_fail++;
        $display("FAIL burst_valid[%0d]: got %b expected %b", i, v, (i >= 1 && i <= 3));
      end
      if (i >= 1 && i <= 3) begin
        n_tests++;
        if (d !== exp_d[i-1]) begin
          n_fail++;
          $display("FAIL burst_data[%0d]: got %h expected %h", i, d, exp_d[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic r, v;
    logic [DW-1:0] d, first;
    int pops;
    pops = 0;
    for (int i = 0; i < 5; i++) src.push_back(DW'($urandom));
    first = src[0];
    n_xfer = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, r, v, d);
      if (r) pops++;
    end
    #1;
    n_tests++;
    if (pops != 2 || occupancy !== 2'd2 || fifo_rd_en !== 1'b0 || m_data !== first) begin
      n_fail++;
      $display("FAIL backpressure_hold: got pops=%0d occ=%0d rd=%b data=%h expected 2/2/0/%h",
               pops, occupancy, fifo_rd_en, m_data, first);
    end
    drain(20);
    n_tests++;
    if (n_xfer != 5) begin
      n_fail++;
      $display("FAIL backpressure_xfers: got %0d expected 5", n_xfer);
    end
  endtask

  task automatic test_wr_act;
    logic r, v;
    logic [DW-1:0] d;
    src.push_back(8'h5C);
    src.push_back(8'hC5);
    step(1'b1, 1'b1, r, v, d);
    n_tests++;
    if (r !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_act_defer: got rd_en %b expected 0", r);
    end
    step(1'b0, 1'b1, r, v, d);
    n_tests++;
    if (r !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_act_next: got rd_en %b expected 1", r);
    end
    drain(10);
  endtask

  task automatic test_reset_full;
    logic r, v;
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) src.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, r, v, d);
    rst = 1'b1;
    step(1'b0, 1'b0, r, v, d);
    rst = 1'b0;
    #1;
    n_tests++;
    if (occupancy !== 2'd0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_full: got occ=%0d vld=%b data=%h expected 0/0/00", occupancy, m_valid, m_data);
    end
    n_xfer = 0;
    drain(10);
    n_tests++;
    if (n_xfer != 2) begin
      n_fail++;
      $display("FAIL reset_full_xfers: got %0d expected 2", n_xfer);
    end
  endtask

  task automatic test_random;
    logic r, v;
    logic [DW-1:0] d;
    int pushed;
    pushed = 0;
    n_xfer = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && src.size() < 8) begin
        src.push_back(DW'($urandom));
        pushed++;
      end
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), r, v, d);
    end
    drain(30);
    n_tests++;
    if (n_xfer != pushed) begin
      n_fail++;
      $display("FAIL random_count: got %0d transfers expected %0d", n_xfer, pushed);
    end
  endtask

`ifdef READER_POP_COUNT_EN
  task automatic test_pop_count;
    logic r, v;
    logic [DW-1:0] d;
    rst = 1'b1;
    step(1'b0, 1'b1, r, v, d);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) src.push_back(DW'(i));
    drain(30);
    #1;
    n_tests++;
    if (pop_count !== 4'd1) begin
      n_fail++;
      $display("FAIL pop_count_wrap: got %0d expected 1", pop_count);
    end
    rst = 1'b1;
    step(1'b0, 1'b1, r, v, d);
    rst = 1'b0;
    #1;
    n_tests++;
    if (pop_count !== 4'd0) begin
      n_fail++;
      $display("FAIL pop_count_reset: got %0d expected 0", pop_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_wr_act();
    test_reset_full();
    test_random();
`ifdef READER_POP_COUNT_EN
    test_pop_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
